multicore_bus_controller: RTL

MULTICORE_BUS_CONTROLLER -- requirements
Module: multicore_bus_controller

---
 rtl/cpu_types_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/multicore_bus_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the multicore bus controller.
//   word_t      : one bus word (address or data)
//   ramstate_t  : handshake state reported by the memory
//   busstate_t  : controller bus state
//   cnt_width() : word-counter width for a given block size. A one-word
//                 block still gets a 1-bit counter.
package cpu_types_pkg;

  localparam int NCPU_DEF     = 2;
  localparam int BLKWORDS_DEF = 2;
  localparam int WORD_W       = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    WB     = 3'd2,
    SNOOP  = 3'd3,
    C2C    = 3'd4,
    M2C    = 3'd5
  } busstate_t;

  function automatic int cnt_width(input int blkwords);
    return (blkwords > 1) ? $clog2(blkwords) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the bus controller.
// The scan starts at core ptr and wraps modulo NCPU. The first requesting
// core wins the grant.
//   req         : per-core request vector
//   ptr         : core index where the scan starts
//   done_idx    : index of the core whose transaction is finishing
//   grant       : one-hot grant
//   grant_idx   : index of the granted core
//   grant_valid : at least one request is present
//   next_ptr    : (done_idx + 1) mod NCPU, the pointer to reload on return to IDLE
module rr_arbiter #(
  parameter int NCPU = 2,
  parameter int IDXW = $clog2(NCPU)
) (
  input  logic [NCPU-1:0] req,
  input  logic [IDXW-1:0] ptr,
  input  logic [IDXW-1:0] done_idx,
  output logic [NCPU-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic [IDXW-1:0] next_ptr
);

  int k;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    k           = 0;
    for (int i = 0; i < NCPU; i++) begin
      // NCPU need not be a power of two, so wrap explicitly.
      k = int'(ptr) + i;
      if (k >= NCPU) k = k - NCPU;
      if (!grant_valid && req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = IDXW'(k);
        grant[k]    = 1'b1;
      end
    end
  end

  assign next_ptr = (int'(done_idx) == NCPU - 1) ? '0 : done_idx + 1'b1;

endmodule

// File: rtl/multicore_bus_controller.sv
// Shared-bus controller for NCPU cores that snoop each other's caches.
// It grants one core at a time, round-robin. The granted core's request
// selects one transaction type:
//   - instruction fetch (IFETCH)
//   - block write-back (WB)
//   - data read (SNOOP, then C2C or M2C)
// A data read first snoops the other cores. A peer holding modified data
// (dWEN & ccwrite) supplies the block directly; the block is written back
// to memory on the same beats. Otherwise the block comes from memory.
// Ports:
//   CLK, RST              : clock and synchronous active-high reset
//   iREN/dREN/dWEN        : per-core requests
//   iaddr/daddr/dstore    : per-core addresses and write data
//   ccwrite/cctrans       : per-core coherence intent and transition flag
//   iwait/dwait           : per-core stalls
//   iload/dload           : per-core read data
//   ccwait/ccinv/
//   ccsnoopaddr           : snoop hold, invalidate and snoop address
//   ramREN/ramWEN/ramaddr/
//   ramstore/ramload/
//   ramstate              : memory side
module multicore_bus_controller
  import cpu_types_pkg::*;
#(
  parameter int NCPU     = NCPU_DEF,
  parameter int BLKWORDS = BLKWORDS_DEF,
  parameter int ADDRW    = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NCPU-1:0]            iREN,
  input  logic [NCPU-1:0]            dREN,
  input  logic [NCPU-1:0]            dWEN,
  input  logic [NCPU-1:0][ADDRW-1:0] iaddr,
  input  logic [NCPU-1:0][ADDRW-1:0] daddr,
  input  logic [NCPU-1:0][ADDRW-1:0] dstore,
  input  logic [NCPU-1:0]            ccwrite,
  input  logic [NCPU-1:0]            cctrans,
  output logic [NCPU-1:0]            iwait,
  output logic [NCPU-1:0]            dwait,
  output logic [NCPU-1:0][ADDRW-1:0] iload,
  output logic [NCPU-1:0][ADDRW-1:0] dload,
  output logic [NCPU-1:0]            ccwait,
  output logic [NCPU-1:0]            ccinv,
  output logic [NCPU-1:0][ADDRW-1:0] ccsnoopaddr,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [ADDRW-1:0]           ramaddr,
  output logic [ADDRW-1:0]           ramstore,
  input  logic [ADDRW-1:0]           ramload,
  input  ramstate_t                  ramstate
);

  localparam int IDXW = $clog2(NCPU);
  localparam int CNTW = cnt_width(BLKWORDS);
  localparam logic [CNTW-1:0] LAST_WORD = CNTW'(BLKWORDS - 1);

  busstate_t       state_reg, state_next;
  logic [IDXW-1:0] rr_reg, rr_next;
  logic [IDXW-1:0] g_reg, g_next;
  logic [IDXW-1:0] r_reg, r_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;

  logic [NCPU-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_valid;
  logic [IDXW-1:0] next_ptr;

  logic [NCPU-1:0] peer;
  logic            resp_found;
  logic [IDXW-1:0] resp_idx;
  logic            access;
  logic            data_state;

  // cctrans carries no bus-side behaviour in this controller.
  logic unused_cctrans;
  assign unused_cctrans = ^cctrans;

  assign access     = (ramstate == ACCESS);
  assign data_state = (state_reg == WB) || (state_reg == C2C) || (state_reg == M2C);

  rr_arbiter #(
    .NCPU (NCPU),
    .IDXW (IDXW)
  ) u_arb (
    .req         (iREN | dREN | dWEN),
    .ptr         (rr_reg),
    .done_idx    (g_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .next_ptr    (next_ptr)
  );

  // Every core other than the granted one.
  generate
    for (genvar gi = 0; gi < NCPU; gi++) begin : g_peer
      assign peer[gi] = (IDXW'(gi) != g_reg);
    end
  endgenerate

  // Responder: the lowest-index peer holding a modified copy.
  always_comb begin
    resp_found = 1'b0;
    resp_idx   = '0;
    for (int k = 0; k < NCPU; k++) begin
      if (!resp_found && peer[k] && dWEN[k] && ccwrite[k]) begin
        resp_found = 1'b1;
        resp_idx   = IDXW'(k);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      rr_reg    <= '0;
      g_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      g_reg     <= g_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    rr_next     = rr_reg;
    g_next      = g_reg;
    r_next      = r_reg;
    cnt_next    = cnt_reg;
    iwait       = '0;
    dwait       = '0;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    // Outputs stay quiet while reset is held, whatever the state.
    if (!RST) begin
      unique case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            g_next = grant_idx;
            if (|(grant & iREN))      state_next = IFETCH;
            else if (|(grant & dWEN)) state_next = WB;
            else                      state_next = SNOOP;
          end
        end
        IFETCH: begin
          ramREN       = 1'b1;
          ramaddr      = iaddr[g_reg];
          iload[g_reg] = ramload;
          iwait[g_reg] = !access;
          if (access) begin
            state_next = IDLE;
            rr_next    = next_ptr;
          end
        end
        WB: begin
          ramWEN       = 1'b1;
          ramaddr      = daddr[g_reg];
          ramstore     = dstore[g_reg];
          dwait[g_reg] = !access;
        end
        SNOOP: begin
          for (int k = 0; k < NCPU; k++) begin
            if (peer[k]) begin
              ccwait[k]      = 1'b1;
              ccsnoopaddr[k] = daddr[g_reg];
              ccinv[k]       = ccwrite[g_reg];
            end
          end
          if (resp_found) begin
            r_next     = resp_idx;
            state_next = C2C;
          end else begin
            state_next = M2C;
          end
        end
        C2C: begin
          // The responder's block goes to the requester and to memory on
          // the same beats. Snooped peers stay held until the block is done.
          dload[g_reg] = dstore[r_reg];
          ramWEN       = 1'b1;
          ramaddr      = daddr[r_reg];
          ramstore     = dstore[r_reg];
          dwait[g_reg] = !access;
          dwait[r_reg] = !access;
          ccwait       = peer;
        end
        M2C: begin
          ramREN       = 1'b1;
          ramaddr      = daddr[g_reg];
          dload[g_reg] = ramload;
          dwait        = '1;
          dwait[g_reg] = !access;
        end
        default: state_next = IDLE;
      endcase

      // Block beats: only ACCESS advances; BUSY, FREE and ERROR just stall.
      if (data_state && access) begin
        if (cnt_reg == LAST_WORD) begin
          cnt_next   = '0;
          state_next = IDLE;
          rr_next    = next_ptr;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule
